// File: rtl/ascon_fsm_ctrl_if.sv
// Control/handshake bundle between the ASCON controller (master) and the
// datapath plus data source (slave).
interface ascon_fsm_ctrl_if;
  logic       start_i;
  logic       data_valid_i;
  logic [3:0] round_o;
  logic       data_sel_o;
  logic       en_reg_state_o;
  logic       en_xor_data_o;
  logic       en_xor_key_o;
  logic       en_xor_key_end_o;
  logic       en_xor_lsb_o;
  logic       en_cipher_o;
  logic       en_tag_o;
  logic       data_req_o;
  logic       cipher_valid_o;
  logic       done_o;
  logic       busy_o;
  logic [7:0] block_idx_o;

  modport master (
    input  start_i, data_valid_i,
    output round_o, data_sel_o, en_reg_state_o, en_xor_data_o, en_xor_key_o,
           en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o, data_req_o,
           cipher_valid_o, done_o, busy_o, block_idx_o
  );

  modport slave (
    output start_i, data_valid_i,
    input  round_o, data_sel_o, en_reg_state_o, en_xor_data_o, en_xor_key_o,
           en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o, data_req_o,
           cipher_valid_o, done_o, busy_o, block_idx_o
  );
endinterface

// File: rtl/ascon_fsm_ctrl.sv
// ASCON-128 phase sequencer: init (pa), one AD block (pb), NB_PT_BLOCKS
// plaintext blocks and finalisation (pa); Moore-decoded datapath enables.
module ascon_fsm_ctrl #(
  parameter int unsigned NB_PT_BLOCKS = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  ascon_fsm_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_WAIT_AD = 3'd2;
  localparam logic [2:0] S_AD      = 3'd3;
  localparam logic [2:0] S_WAIT_PT = 3'd4;
  localparam logic [2:0] S_PT      = 3'd5;
  localparam logic [2:0] S_FINAL   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [7:0] LAST_BLK = 8'(NB_PT_BLOCKS - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic [7:0] blk;
  logic       cipher_valid;

  logic in_round, at_r0, at_r6, at_r11, en_cipher;

  always_comb begin
    in_round  = (state == S_INIT) || (state == S_AD) ||
                (state == S_PT)   || (state == S_FINAL);
    at_r0     = (cnt == 4'd0);
    at_r6     = (cnt == 4'd6);
    at_r11    = (cnt == 4'd11);
    en_cipher = ((state == S_PT) && at_r6) || ((state == S_FINAL) && at_r0);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      blk          <= '0;
      cipher_valid <= 1'b0;
    end else begin
      cipher_valid <= en_cipher;
      case (state)
        S_IDLE: if (bus.start_i) begin
          state <= S_INIT;
          cnt   <= '0;
          blk   <= '0;
        end
        S_INIT: if (at_r11) state <= S_WAIT_AD;
                else        cnt   <= cnt + 4'd1;
        S_WAIT_AD: if (bus.data_valid_i) begin
          state <= S_AD;
          cnt   <= 4'd6;
        end
        S_AD: if (at_r11) begin
          state <= S_WAIT_PT;
          blk   <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
        // The last block skips PT: its absorb/encrypt happens at FINAL round 0.
        S_WAIT_PT: if (bus.data_valid_i) begin
          if (blk < LAST_BLK) begin
            state <= S_PT;
            cnt   <= 4'd6;
          end else begin
            state <= S_FINAL;
            cnt   <= '0;
          end
        end
        S_PT: if (at_r11) begin
          state <= S_WAIT_PT;
          blk   <= blk + 8'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
        S_FINAL: if (at_r11) state <= S_DONE;
                 else        cnt   <= cnt + 4'd1;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.round_o          = in_round ? cnt : '0;
  assign bus.data_sel_o       = (state == S_INIT) && at_r0;
  assign bus.en_reg_state_o   = in_round;
  assign bus.en_xor_data_o    = (((state == S_AD) || (state == S_PT)) && at_r6) ||
                                ((state == S_FINAL) && at_r0);
  assign bus.en_xor_key_o     = (state == S_FINAL) && at_r0;
  assign bus.en_xor_key_end_o = ((state == S_INIT) || (state == S_FINAL)) && at_r11;
  assign bus.en_xor_lsb_o     = (state == S_AD) && at_r11;
  assign bus.en_cipher_o      = en_cipher;
  assign bus.en_tag_o         = (state == S_FINAL) && at_r11;
  assign bus.data_req_o       = (state == S_WAIT_AD) || (state == S_WAIT_PT);
  assign bus.cipher_valid_o   = cipher_valid;
  assign bus.done_o           = (state == S_DONE);
  assign bus.busy_o           = (state != S_IDLE);
  assign bus.block_idx_o      = blk;

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Bench for ascon_fsm_ctrl: a phase-level schedule model predicts every
// output per cycle for NB_PT_BLOCKS=4 and NB_PT_BLOCKS=1 instances.
module tb_ascon_fsm_ctrl;

  typedef struct packed {
    logic [3:0] round;
    logic       sel, reg_en, xdata, xkey, xkend, xlsb, cipher, tag;
    logic       req, cvalid, done, busy;
    logic [7:0] bidx;
  } obs_t;

  localparam int PH_INIT = 0, PH_AD = 1, PH_PT = 2, PH_FIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  obs_t exp_q[$];
  int   dv_q[$];     // 0/1 forced data_valid, 2 = don't care (random)
  int   stall_q[$];  // stall cycles per wait state, in order

  ascon_fsm_ctrl_if bus4();
  ascon_fsm_ctrl_if bus1();

  ascon_fsm_ctrl #(.NB_PT_BLOCKS(4)) dut4 (.clock_i(clk), .reset_i(rst), .bus(bus4));
  ascon_fsm_ctrl #(.NB_PT_BLOCKS(1)) dut1 (.clock_i(clk), .reset_i(rst), .bus(bus1));

  always #5 clk = ~clk;

  obs_t obs4, obs1;
  assign obs4 = {bus4.round_o, bus4.data_sel_o, bus4.en_reg_state_o, bus4.en_xor_data_o,
                 bus4.en_xor_key_o, bus4.en_xor_key_end_o, bus4.en_xor_lsb_o,
                 bus4.en_cipher_o, bus4.en_tag_o, bus4.data_req_o, bus4.cipher_valid_o,
                 bus4.done_o, bus4.busy_o, bus4.block_idx_o};
  assign obs1 = {bus1.round_o, bus1.data_sel_o, bus1.en_reg_state_o, bus1.en_xor_data_o,
                 bus1.en_xor_key_o, bus1.en_xor_key_end_o, bus1.en_xor_lsb_o,
                 bus1.en_cipher_o, bus1.en_tag_o, bus1.data_req_o, bus1.cipher_valid_o,
                 bus1.done_o, bus1.busy_o, bus1.block_idx_o};

  task automatic drive(input int which, input logic s, input logic d);
    if (which == 4) begin bus4.start_i = s; bus4.data_valid_i = d; end
    else            begin bus1.start_i = s; bus1.data_valid_i = d; end
  endtask

  // ---------------- reference schedule ----------------
  task automatic add_round(input int ph, input int r, input int b);
    obs_t o = '0;
    o.round = 4'(r); o.reg_en = 1'b1; o.busy = 1'b1; o.bidx = 8'(b);
    case (ph)
      PH_INIT: begin o.sel = (r == 0); o.xkend = (r == 11); end
      PH_AD:   begin o.xdata = (r == 6); o.xlsb = (r == 11); end
      PH_PT:   begin o.xdata = (r == 6); o.cipher = (r == 6); end
      default: begin
        o.xdata = (r == 0); o.xkey = (r == 0); o.cipher = (r == 0);
        o.xkend = (r == 11); o.tag = (r == 11);
      end
    endcase
    exp_q.push_back(o);
    dv_q.push_back(2);
  endtask

  task automatic add_wait(input int b, input int stall);
    for (int i = 0; i <= stall; i++) begin
      obs_t o = '0;
      o.req = 1'b1; o.busy = 1'b1; o.bidx = 8'(b);
      exp_q.push_back(o);
      dv_q.push_back((i == stall) ? 1 : 0);
    end
  endtask

  task automatic build_model(input int nb);
    obs_t o;
    exp_q.delete(); dv_q.delete();
    for (int r = 0; r < 12; r++) add_round(PH_INIT, r, 0);
    add_wait(0, stall_q[0]);
    for (int r = 6; r < 12; r++) add_round(PH_AD, r, 0);
    for (int b = 0; b < nb; b++) begin
      add_wait(b, stall_q[b+1]);
      if (b < nb - 1) for (int r = 6; r < 12; r++) add_round(PH_PT, r, b);
    end
    for (int r = 0; r < 12; r++) add_round(PH_FIN, r, nb - 1);
    o = '0; o.done = 1'b1; o.busy = 1'b1; o.bidx = 8'(nb - 1);
    exp_q.push_back(o); dv_q.push_back(2);
    o = '0; o.bidx = 8'(nb - 1);
    exp_q.push_back(o); dv_q.push_back(2);
    for (int k = exp_q.size() - 1; k > 0; k--) begin
      o = exp_q[k]; o.cvalid = exp_q[k-1].cipher; exp_q[k] = o;
    end
  endtask

  task automatic set_stalls(input int nb, input int mode, input int val);
    stall_q.delete();
    for (int i = 0; i <= nb; i++)
      stall_q.push_back(mode == 0 ? val : int'($urandom_range(0, 4)));
  endtask

  function automatic int zero_wait_latency(input int nb);
    return 12 + 1 + 6 + (nb - 1) * 7 + 1 + 12 + 1;
  endfunction

  function automatic int stall_sum();
    int s = 0;
    foreach (stall_q[i]) s += stall_q[i];
    return s;
  endfunction

  // Plays the schedule: cycle 0 issues start, record k-1 is checked in cycle k.
  task automatic run_trace(input int which, input bit hold_dv, input bit rand_start,
                           input int abort_at, output int done_cyc, output int cv_cnt,
                           output int n_kend, output int n_lsb, output int n_sel,
                           output int n_key);
    obs_t o, e;
    logic d;
    done_cyc = -1; cv_cnt = 0; n_kend = 0; n_lsb = 0; n_sel = 0; n_key = 0;
    @(negedge clk);
    drive(which, 1'b1, hold_dv ? 1'b1 : 1'($urandom_range(0, 1)));
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      o = (which == 4) ? obs4 : obs1;
      e = exp_q[k-1];
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL trace nb%0d cycle %0d: got %h want %h", which, k, o, e);
      end
      if (o.done === 1'b1 && done_cyc < 0) done_cyc = k;
      if (o.cvalid === 1'b1) cv_cnt++;
      if (o.xkend === 1'b1) n_kend++;
      if (o.xlsb === 1'b1) n_lsb++;
      if (o.sel === 1'b1) n_sel++;
      if (o.xkey === 1'b1) n_key++;
      if (k - 1 == abort_at) begin
        rst = 1'b1;
        drive(which, 1'b0, 1'b0);
        break;
      end
      if (dv_q[k-1] == 2) d = hold_dv ? 1'b1 : 1'($urandom_range(0, 1));
      else                d = 1'(dv_q[k-1]);
      drive(which, (rand_start && (k - 1 <= exp_q.size() - 2)) ? 1'($urandom_range(0, 1)) : 1'b0, d);
    end
    drive(which, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    drive(4, 1'b1, 1'b1); drive(1, 1'b1, 1'b1);
    repeat (2) begin
      @(negedge clk);
      tests++; if (obs4 !== '0) begin fails++; $display("FAIL reset_nb4: got %h want 0", obs4); end
      tests++; if (obs1 !== '0) begin fails++; $display("FAIL reset_nb1: got %h want 0", obs1); end
    end
    rst = 1'b0;
    drive(4, 1'b0, 1'b0); drive(1, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      tests++; if (obs4 !== '0) begin fails++; $display("FAIL idle_nb4: got %h want 0", obs4); end
      tests++; if (obs1 !== '0) begin fails++; $display("FAIL idle_nb1: got %h want 0", obs1); end
    end
  endtask

  task automatic test_full_run;
    int dc, cv, nk, nl, ns, nx;
    set_stalls(4, 0, 0);
    build_model(4);
    run_trace(4, 1'b1, 1'b0, -1, dc, cv, nk, nl, ns, nx);
    tests++; if (dc != 54) begin fails++; $display("FAIL full_latency: got %0d want 54", dc); end
    tests++; if (cv != 4) begin fails++; $display("FAIL full_cvalid: got %0d want 4", cv); end
    tests++; if (nk != 2) begin fails++; $display("FAIL key_end_count: got %0d want 2", nk); end
    tests++; if (nl != 1) begin fails++; $display("FAIL lsb_count: got %0d want 1", nl); end
    tests++; if (ns != 1) begin fails++; $display("FAIL sel_count: got %0d want 1", ns); end
    tests++; if (nx != 1) begin fails++; $display("FAIL key_count: got %0d want 1", nx); end
  endtask

  task automatic test_stalled;
    int dc, cv, nk, nl, ns, nx;
    set_stalls(4, 0, 10);
    build_model(4);
    run_trace(4, 1'b0, 1'b1, -1, dc, cv, nk, nl, ns, nx);
    tests++; if (dc != 104) begin fails++; $display("FAIL stall_latency: got %0d want 104", dc); end
    tests++; if (cv != 4) begin fails++; $display("FAIL stall_cvalid: got %0d want 4", cv); end
  endtask

  task automatic test_random_runs;
    int dc, cv, nk, nl, ns, nx, want;
    for (int n = 0; n < 4; n++) begin
      set_stalls(4, 1, 0);
      want = zero_wait_latency(4) + stall_sum();
      build_model(4);
      run_trace(4, 1'b0, 1'b1, -1, dc, cv, nk, nl, ns, nx);
      tests++; if (dc != want) begin fails++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, dc, want); end
    end
  endtask

  task automatic test_reset_mid;
    int dc, cv, nk, nl, ns, nx;
    set_stalls(4, 0, 0);
    build_model(4);
    run_trace(4, 1'b0, 1'b1, 22, dc, cv, nk, nl, ns, nx);
    @(negedge clk);
    tests++; if (obs4 !== '0) begin fails++; $display("FAIL reset_mid: got %h want 0", obs4); end
    rst = 1'b0;
    run_trace(4, 1'b1, 1'b0, -1, dc, cv, nk, nl, ns, nx);
    tests++; if (dc != 54) begin fails++; $display("FAIL after_reset_latency: got %0d want 54", dc); end
  endtask

  task automatic test_single_block;
    int dc, cv, nk, nl, ns, nx, want;
    for (int n = 0; n < 2; n++) begin
      set_stalls(1, n, 0);
      want = zero_wait_latency(1) + stall_sum();
      build_model(1);
      run_trace(1, 1'b0, 1'b1, -1, dc, cv, nk, nl, ns, nx);
      tests++; if (dc != want) begin fails++; $display("FAIL nb1_latency[%0d]: got %0d want %0d", n, dc, want); end
      tests++; if (cv != 1) begin fails++; $display("FAIL nb1_cvalid[%0d]: got %0d want 1", n, cv); end
    end
  endtask

  initial begin
    bus4.start_i = 1'b0; bus4.data_valid_i = 1'b0;
    bus1.start_i = 1'b0; bus1.data_valid_i = 1'b0;
    test_reset();
    test_full_run();
    test_stalled();
    test_random_runs();
    test_reset_mid();
    test_single_block();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
